// File: rtl/mult32x32_arbiter.sv
// mult32x32_arbiter: round-robin scheduler sharing one mult32x32 among NREQ requesters.
// Optional feature macro: MULT_ARB_TIMEOUT_EN (watchdog on the multiplier busy handshake).
module mult32x32_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   a_in,
    input  logic [NREQ*32-1:0]   b_in,
    output logic [NREQ-1:0]      done,
    output logic [63:0]          rsp_product,
    output logic                 err,
    output logic                 arb_busy,
    output logic                 m_start,
    output logic [31:0]          m_a,
    output logic [31:0]          m_b,
    input  logic                 m_busy,
    input  logic [63:0]          m_product
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]     state_q;
    logic [2:0]     state_d;
    logic [IDW-1:0] rr_q;
    logic [IDW-1:0] id_q;
    logic           grant_vld;
    logic [IDW-1:0] grant_id;
    logic [31:0]    a_sel;
    logic [31:0]    b_sel;
    logic           timeout_c;

    // Requester index at offset off above base, wrapping NREQ-1 -> 0.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IDW'(s % NREQ);
    endfunction

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 3);
    logic [CW-1:0] tmo_cnt;

    // Cycles spent in the current state; restarts on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != {CW{1'b1}}) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Round-robin grant search, operand mux and next-state logic.
    always_comb begin
        state_d   = state_q;
        timeout_c = 1'b0;
        grant_vld = 1'b0;
        grant_id  = '0;
        a_sel     = '0;
        b_sel     = '0;

        for (int k = 0; k < int'(NREQ); k++) begin
            if (!grant_vld && req[wrap_idx(rr_q, 32'(k))]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_idx(rr_q, 32'(k));
            end
        end

        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_id == IDW'(i)) begin
                a_sel = a_in[32*i +: 32];
                b_sel = b_in[32*i +: 32];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (m_busy) begin
                    state_d = ST_WAIT_LO;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (tmo_cnt == CW'(2)) begin
                    state_d   = ST_DONE;
                    timeout_c = 1'b1;
                end
`endif
            end
            ST_WAIT_LO: begin
                if (!m_busy) begin
                    state_d = ST_DONE;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (tmo_cnt == CW'(TIMEOUT)) begin
                    state_d   = ST_DONE;
                    timeout_c = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, grant capture and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q        <= '0;
            id_q        <= '0;
            m_start     <= 1'b0;
            m_a         <= '0;
            m_b         <= '0;
            rsp_product <= '0;
            done        <= '0;
            err         <= 1'b0;
            arb_busy    <= 1'b0;
        end else begin
            m_start  <= (state_d == ST_ISSUE);
            arb_busy <= (state_d != ST_IDLE);
            done     <= '0;
            err      <= 1'b0;

            if (state_q == ST_IDLE && grant_vld) begin
                id_q <= grant_id;
                m_a  <= a_sel;
                m_b  <= b_sel;
            end

            if (state_q == ST_WAIT_LO && !m_busy) begin
                rsp_product <= m_product;
            end
            if (timeout_c) begin
                rsp_product <= '0;
            end

            if (state_q != ST_DONE && state_d == ST_DONE) begin
                done <= NREQ'(1) << id_q;
                err  <= timeout_c;
            end

            if (state_q == ST_DONE) begin
                if (id_q == IDW'(NREQ - 1)) rr_q <= '0;
                else                        rr_q <= id_q + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Scoreboard bench for mult32x32_arbiter with a behavioural multiplier stub.
module tb_mult32x32_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*32-1:0]  a_in;
    logic [NREQ*32-1:0]  b_in;
    logic [NREQ-1:0]     done;
    logic [63:0]         rsp_product;
    logic                err;
    logic                arb_busy;
    logic                m_start;
    logic [31:0]         m_a;
    logic [31:0]         m_b;
    logic                m_busy;
    logic [63:0]         m_product;

    always #5 clk = ~clk;

    mult32x32_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
        .done(done), .rsp_product(rsp_product), .err(err), .arb_busy(arb_busy),
        .m_start(m_start), .m_a(m_a), .m_b(m_b), .m_busy(m_busy), .m_product(m_product)
    );

    // Multiplier stub: busy for lat_next cycles, product formed from m_a/m_b at the end.
    int  lat_next = 3;
    int  mcnt;
    bit  hold_busy = 1'b0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy    <= 1'b0;
            m_product <= '0;
            mcnt      <= 0;
        end else if (!m_busy) begin
            if (m_start) begin
                m_busy <= 1'b1;
                mcnt   <= lat_next;
            end
        end else if (!hold_busy) begin
            if (mcnt <= 1) begin
                m_busy    <= 1'b0;
                m_product <= 64'(m_a) * 64'(m_b);
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [NREQ-1:0] d;
        logic [63:0]     p;
        logic            e;
        logic            f;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [63:0] iss_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model_rr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        a_in[32*i +: 32] = a;
        b_in[32*i +: 32] = b;
        req[i]           = 1'b1;
    endtask

    // Reference: pick next requester by round-robin over the current req, predict the
    // response, then wait (bounded) for the completion pulse.
    task automatic grant_and_wait(input bit from_idle, input bit scr_en,
                                  input logic [31:0] scr_val, input bit tmo, output int w);
        logic [31:0] a;
        logic [31:0] b;
        rsp_t        r;
        bit          got;
        int          issue_cyc;
        w = -1;
        for (int k = 0; k < int'(NREQ); k++) begin
            int j;
            j = (model_rr + k) % int'(NREQ);
            if (w < 0 && req[j]) w = j;
        end
        if (w < 0) return;
        a = a_in[32*w +: 32];
        b = b_in[32*w +: 32];
        iss_q.push_back({a, b});
        r.d = NREQ'(1) << w;
        r.p = tmo ? 64'd0 : 64'(a) * 64'(b);
        r.e = tmo;
        r.f = !tmo;
        rsp_q.push_back(r);
        model_rr  = (w + 1) % int'(NREQ);
        lat_next  = int'($urandom_range(1, 6));
        issue_cyc = from_idle ? 1 : 2;
        got       = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == issue_cyc) begin
                chk("m_start_latency", 64'(m_start), 64'd1);
                if (scr_en) a_in[32*w +: 32] = scr_val;
            end
            if (done != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done for requester %0d", w);
        end
    endtask

    // Monitor: compares every issue and completion against the scoreboard queues.
    initial begin
        rsp_t        r;
        logic [63:0] e;
        logic        b1;
        logic        b2;
        b1 = 1'b0;
        b2 = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                b1 = 1'b0;
                b2 = 1'b0;
            end else begin
                if (m_start) begin
                    if (iss_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_m_start: got m_start=1 expected 0");
                    end else begin
                        e = iss_q.pop_front();
                        chk("m_a", 64'(m_a), 64'(e[63:32]));
                        chk("m_b", 64'(m_b), 64'(e[31:0]));
                        chk("arb_busy_issue", 64'(arb_busy), 64'd1);
                    end
                end
                if (done != '0) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got %b expected 0", done);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("done", 64'(done), 64'(r.d));
                        chk("rsp_product", rsp_product, r.p);
                        chk("err", 64'(err), 64'(r.e));
                        chk("arb_busy_done", 64'(arb_busy), 64'd1);
                        if (r.f) chk("done_after_busy_fall", 64'({b2, b1}), 64'd2);
                    end
                end
                b2 = b1;
                b1 = m_busy;
            end
        end
    end

    initial begin
        int w;
        int ops;
        bit from_idle;
        reset = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", rsp_product, 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_arb_busy", 64'(arb_busy), 64'd0);
        chk("reset_m_start", 64'(m_start), 64'd0);
        chk("reset_m_ab", {m_a, m_b}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single request, then all-ones operands on requester 2.
        set_op(0, 32'd3, 32'd5);
        grant_and_wait(1'b1, 1'b0, 32'd0, 1'b0, w);
        req = '0;
        repeat (2) @(negedge clk);
        set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        grant_and_wait(1'b1, 1'b0, 32'd0, 1'b0, w);
        req = '0;
        repeat (2) @(negedge clk);

        // Contention: all requesters held high with the same operands.
        for (int i = 0; i < int'(NREQ); i++) set_op(i, 32'(i + 1), 32'd10);
        grant_and_wait(1'b1, 1'b0, 32'd0, 1'b0, w);
        for (int n = 0; n < 7; n++) grant_and_wait(1'b0, 1'b0, 32'd0, 1'b0, w);
        req = '0;
        repeat (2) @(negedge clk);

        // Operand hold: a_in changes during ISSUE must not reach the multiplier.
        set_op(0, 32'd7, 32'd2);
        grant_and_wait(1'b1, 1'b1, 32'd9, 1'b0, w);
        req = '0;

        // Randomised traffic.
        ops = 0;
        while (ops < 60) begin
            if (req == '0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                for (int i = 0; i < int'(NREQ); i++)
                    if ($urandom_range(0, 1) == 1) set_op(i, $urandom, $urandom);
                if (req == '0) set_op(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom);
                from_idle = 1'b1;
            end else begin
                from_idle = 1'b0;
            end
            grant_and_wait(from_idle, $urandom_range(0, 3) == 0, $urandom, 1'b0, w);
            ops++;
            if (w >= 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    a_in[32*w +: 32] = $urandom;
                    b_in[32*w +: 32] = $urandom;
                end else begin
                    req[w] = 1'b0;
                end
            end
            for (int i = 0; i < int'(NREQ); i++)
                if (!req[i] && i != w && $urandom_range(0, 9) < 3) set_op(i, $urandom, $urandom);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Reset in WAIT_LO: outputs clear at once and the killed operation never completes.
        lat_next = 10;
        set_op(0, 32'd5, 32'd6);
        iss_q.push_back({32'd5, 32'd6});
        for (int c = 0; c < 40 && !m_busy; c++) @(negedge clk);
        chk("busy_before_reset", 64'(m_busy), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        req   = '0;
        #1;
        chk("midop_done", 64'(done), 64'd0);
        chk("midop_product", rsp_product, 64'd0);
        chk("midop_flags", 64'({err, arb_busy, m_start}), 64'd0);
        chk("midop_m_ab", {m_a, m_b}, 64'd0);
        model_rr = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("midop_no_rsp_pending", 64'(rsp_q.size()), 64'd0);
        set_op(1, 32'd4, 32'd4);
        grant_and_wait(1'b1, 1'b0, 32'd0, 1'b0, w);
        req = '0;
        repeat (2) @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
        // Stuck multiplier: watchdog completes with err, then normal service resumes.
        hold_busy = 1'b1;
        set_op(0, 32'd11, 32'd13);
        grant_and_wait(1'b1, 1'b0, 32'd0, 1'b1, w);
        req       = '0;
        hold_busy = 1'b0;
        for (int c = 0; c < 40 && m_busy; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        set_op(0, 32'd3, 32'd7);
        grant_and_wait(1'b1, 1'b0, 32'd0, 1'b0, w);
        req = '0;
        repeat (2) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drain_rsp", 64'(rsp_q.size()), 64'd0);
        chk("scoreboard_drain_iss", 64'(iss_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
